// File: rtl/truth_table_sweep_if.sv
// truth_table_sweep_if
//
// Groups the stimulus/capture signals of the truth-table sweeper into one
// bundle. The clock and reset are not part of the bundle and stay plain
// ports on the sweeper.
//
// Signals:
//   start          begin a sweep (taken only while the sweeper is idle)
//   f              output of the block under test
//   golden         expected table, bit k is expected f for vector k
//   vec            stimulus vector driven into the block under test
//   busy           high while a sweep is running
//   done           one-cycle pulse when a sweep completes
//   table_out      captured table, bit k is f sampled for vector k
//   mismatch_count number of captured bits that differ from golden
//   pass           last completed sweep had zero mismatches
//
// Modports:
//   master  the side that owns the block under test and reads results
//   slave   the sweeper itself
interface truth_table_sweep_if #(
    parameter int N_IN = 4
);
    logic                   start;
    logic                   f;
    logic [(1<<N_IN)-1:0]   golden;
    logic [N_IN-1:0]        vec;
    logic                   busy;
    logic                   done;
    logic [(1<<N_IN)-1:0]   table_out;
    logic [N_IN:0]          mismatch_count;
    logic                   pass;

    modport master (
        output start, f, golden,
        input  vec, busy, done, table_out, mismatch_count, pass
    );

    modport slave (
        input  start, f, golden,
        output vec, busy, done, table_out, mismatch_count, pass
    );
endinterface

// File: rtl/truth_table_sweep.sv
// truth_table_sweep
//
// Exhaustive stimulus-and-capture stage for a small combinational block.
// A start request walks every N_IN-bit vector in ascending order, holds each
// vector for SETTLE+1 cycles, samples the block output f on the last edge of
// that window into a captured table, and counts differences against a
// golden table. A pass flag and one-cycle done pulse close the sweep.
//
// Parameters:
//   N_IN    number of inputs of the block under test (1..6)
//   SETTLE  extra hold cycles per vector before sampling (0..15)
//
// Ports:
//   clk  rising-edge clock
//   rst  asynchronous active-high reset
//   bus  truth_table_sweep_if slave modport (start, f, golden in;
//        vec, busy, done, table_out, mismatch_count, pass out)
module truth_table_sweep #(
    parameter int N_IN   = 4,
    parameter int SETTLE = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    truth_table_sweep_if.slave   bus
);

    localparam int                TBL_W    = 1 << N_IN;
    localparam logic [N_IN-1:0]   VEC_LAST = {N_IN{1'b1}};
    localparam logic [N_IN-1:0]   VEC_ONE  = 1;
    localparam logic [N_IN:0]     MIS_ZERO = '0;
    localparam logic [3:0]        SETTLE_C = 4'(SETTLE);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FINISH
    } state_t;

    state_t              state_q, state_d;
    logic [N_IN-1:0]     vec_q, vec_d;
    logic [3:0]          cnt_q, cnt_d;
    logic [TBL_W-1:0]    table_q, table_d;
    logic [N_IN:0]       mis_q, mis_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                pass_q, pass_d;

    logic                missBit;
    logic [N_IN:0]       misNext;

    // All architectural state lives here; reset clears everything at once so
    // a reset in the middle of a sweep abandons it without a trace.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            vec_q   <= '0;
            cnt_q   <= '0;
            table_q <= '0;
            mis_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            vec_q   <= vec_d;
            cnt_q   <= cnt_d;
            table_q <= table_d;
            mis_q   <= mis_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            pass_q  <= pass_d;
        end
    end

    // Next-state logic. The settle counter counts up to SETTLE and the edge
    // on which it equals SETTLE is the sample edge for the current vector.
    // The pass flag is derived from the count including the final compare,
    // so it uses misNext rather than the registered count.
    always_comb begin
        state_d = state_q;
        vec_d   = vec_q;
        cnt_d   = cnt_q;
        table_d = table_q;
        mis_d   = mis_q;
        busy_d  = busy_q;
        done_d  = done_q;
        pass_d  = pass_q;
        missBit = bus.f ^ bus.golden[vec_q];
        misNext = mis_q + {{N_IN{1'b0}}, missBit};

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d = RUN;
                    busy_d  = 1'b1;
                    vec_d   = '0;
                    cnt_d   = '0;
                    table_d = '0;
                    mis_d   = '0;
                    pass_d  = 1'b0;
                end
            end

            RUN: begin
                if (cnt_q != SETTLE_C) begin
                    cnt_d = cnt_q + 4'd1;
                end else begin
                    table_d[vec_q] = bus.f;
                    mis_d          = misNext;
                    cnt_d          = '0;
                    if (vec_q != VEC_LAST) begin
                        vec_d = vec_q + VEC_ONE;
                    end else begin
                        state_d = FINISH;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        pass_d  = (misNext == MIS_ZERO);
                    end
                end
            end

            FINISH: begin
                done_d  = 1'b0;
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.vec            = vec_q;
    assign bus.busy           = busy_q;
    assign bus.done           = done_q;
    assign bus.table_out      = table_q;
    assign bus.mismatch_count = mis_q;
    assign bus.pass           = pass_q;

endmodule

// File: tb/tb_truth_table_sweep.sv
// tb_truth_table_sweep
//
// Bench for truth_table_sweep. Two sweepers share clock and reset: one with
// the default timing (N_IN=4, SETTLE=1) in front of an a&b|c&d block that can
// be switched to stuck-at-0, and one with SETTLE=0 in front of f=vec[0].
// Expected sweep results are computed from a reference function when a sweep
// is launched and queued; they are popped when the sweeper raises done.
module tb_truth_table_sweep;

    typedef struct packed {
        logic [15:0] tbl;
        logic [4:0]  mis;
        logic        pass;
    } exp_t;

    logic clk;
    logic rst;
    logic faultMode;

    int   checks;
    int   errors;
    exp_t sb[$];

    truth_table_sweep_if #(.N_IN(4)) bus0 ();
    truth_table_sweep_if #(.N_IN(4)) bus1 ();

    truth_table_sweep #(.N_IN(4), .SETTLE(1)) dut0 (
        .clk (clk),
        .rst (rst),
        .bus (bus0)
    );

    truth_table_sweep #(.N_IN(4), .SETTLE(0)) dut1 (
        .clk (clk),
        .rst (rst),
        .bus (bus1)
    );

    // Blocks under test: a&b | c&d (or stuck at 0) and a plain vec[0] follower.
    assign bus0.f = faultMode ? 1'b0
                              : ((bus0.vec[3] & bus0.vec[2]) | (bus0.vec[1] & bus0.vec[0]));
    assign bus1.f = bus1.vec[0];

    // 100 MHz-style clock; inputs change and outputs are sampled on negedge.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Backstop so a stuck sweeper can never hang the run.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    function automatic logic refF(input int mode, input logic [3:0] v);
        if (mode == 1) return 1'b0;
        if (mode == 2) return v[0];
        return (v[3] & v[2]) | (v[1] & v[0]);
    endfunction

    function automatic exp_t buildExpect(input int mode, input logic [15:0] gold);
        exp_t e;
        e.tbl = '0;
        e.mis = '0;
        for (int k = 0; k < 16; k++) begin
            e.tbl[k] = refF(mode, 4'(k));
            if (e.tbl[k] != gold[k]) e.mis = e.mis + 5'd1;
        end
        e.pass = (e.mis == 5'd0);
        return e;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Load golden / fault selection for dut0 and pulse start for one edge.
    task automatic applyStimulus(input logic [15:0] gold, input logic fault);
        bus0.golden = gold;
        faultMode   = fault;
        bus0.start  = 1'b1;
        @(negedge clk);
        bus0.start  = 1'b0;
    endtask

    task automatic checkResults(input string tag, input logic [15:0] tbl,
                                input logic [4:0] mis, input logic pass);
        checkOutput({tag, " table"}, 32'(tbl), 32'(bus0.table_out));
    endtask

    // Full sweep on dut0 with optional start re-pulse at cycle pokeAt.
    task automatic runSweep0(input logic [15:0] gold, input int mode,
                             input int pokeAt, input string tag);
        exp_t e;
        int   c;
        sb.push_back(buildExpect(mode, gold));
        applyStimulus(gold, (mode == 1));
        c = 0;
        while (bus0.busy === 1'b1 && c < 100) begin
            checkOutput({tag, " vec"}, 32'(bus0.vec), 32'(c / 2));
            bus0.start = (c == pokeAt);
            @(negedge clk);
            c++;
        end
        bus0.start = 1'b0;
        checkOutput({tag, " busy cycles"}, 32'(c), 32'd32);
        checkOutput({tag, " done"}, 32'(bus0.done), 32'd1);
        checkOutput({tag, " sb nonempty"}, 32'(sb.size() > 0), 32'd1);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            checkOutput({tag, " table"}, 32'(bus0.table_out), 32'(e.tbl));
            checkOutput({tag, " mismatches"}, 32'(bus0.mismatch_count), 32'(e.mis));
            checkOutput({tag, " pass"}, 32'(bus0.pass), 32'(e.pass));
            @(negedge clk);
            checkOutput({tag, " done low"}, 32'(bus0.done), 32'd0);
            checkOutput({tag, " vec held"}, 32'(bus0.vec), 32'hF);
            checkOutput({tag, " table held"}, 32'(bus0.table_out), 32'(e.tbl));
            checkOutput({tag, " pass held"}, 32'(bus0.pass), 32'(e.pass));
        end
    endtask

    initial begin
        exp_t e;
        int   c;
        int   doneSeen;

        checks      = 0;
        errors      = 0;
        faultMode   = 1'b0;
        rst         = 1'b1;
        bus0.start  = 1'b0;
        bus0.golden = 16'hF888;
        bus1.start  = 1'b0;
        bus1.golden = 16'hAAAA;

        // Reset for two cycles, then confirm quiet outputs with no start.
        repeat (2) @(negedge clk);
        rst = 1'b0;
        checkOutput("reset vec", 32'(bus0.vec), 32'd0);
        checkOutput("reset busy", 32'(bus0.busy), 32'd0);
        checkOutput("reset done", 32'(bus0.done), 32'd0);
        checkOutput("reset table", 32'(bus0.table_out), 32'd0);
        checkOutput("reset mismatches", 32'(bus0.mismatch_count), 32'd0);
        checkOutput("reset pass", 32'(bus0.pass), 32'd0);
        checkOutput("reset busy1", 32'(bus1.busy), 32'd0);
        doneSeen = 0;
        for (int i = 0; i < 6; i++) begin
            if (bus0.done || bus0.busy || bus1.done || bus1.busy) doneSeen++;
            @(negedge clk);
        end
        checkOutput("idle without start", 32'(doneSeen), 32'd0);

        // Correct block, then stuck-at-0 block, then a start poke mid-sweep.
        runSweep0(16'hF888, 0, -1, "good");
        runSweep0(16'hF888, 1, -1, "faulty");
        runSweep0(16'hF888, 0, 10, "poke");

        // Reset in the middle of a sweep clears everything at once.
        applyStimulus(16'hF888, 1'b0);
        repeat (20) @(negedge clk);
        checkOutput("pre-reset table", 32'(bus0.table_out != 16'h0), 32'd1);
        rst = 1'b1;
        #1;
        checkOutput("midreset vec", 32'(bus0.vec), 32'd0);
        checkOutput("midreset busy", 32'(bus0.busy), 32'd0);
        checkOutput("midreset table", 32'(bus0.table_out), 32'd0);
        checkOutput("midreset mismatches", 32'(bus0.mismatch_count), 32'd0);
        checkOutput("midreset done", 32'(bus0.done), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("no self restart", 32'(bus0.busy), 32'd0);
        runSweep0(16'hF888, 0, -1, "after reset");

        // SETTLE=0 sweeper: one vector per cycle.
        sb.push_back(buildExpect(2, 16'hAAAA));
        bus1.start = 1'b1;
        @(negedge clk);
        bus1.start = 1'b0;
        c = 0;
        while (bus1.busy === 1'b1 && c < 100) begin
            checkOutput("fast vec", 32'(bus1.vec), 32'(c));
            @(negedge clk);
            c++;
        end
        checkOutput("fast busy cycles", 32'(c), 32'd16);
        checkOutput("fast done", 32'(bus1.done), 32'd1);
        checkOutput("fast sb nonempty", 32'(sb.size() > 0), 32'd1);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            checkOutput("fast table", 32'(bus1.table_out), 32'(e.tbl));
            checkOutput("fast mismatches", 32'(bus1.mismatch_count), 32'(e.mis));
            checkOutput("fast pass", 32'(bus1.pass), 32'(e.pass));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
